track_line_gen: RTL
===================

Name: track_line_gen

Overview:
- Per-frame scanline geometry generator for the track renderer.
- On each frame start it computes one 32-bit line word for each of the LINES road scanlines and writes them into the track line RAM.
- The downstream pixel plotter reads that RAM by scanline index.
- Road curvature, perspective narrowing and kerb stripe phase are all derived incrementally from latched scroll_pos and curve, so the block needs no multipliers or dividers.

Parameters:
- LINES, 240: number of road scanlines generated; RAM address range is 0..LINES-1.
- HALF_MIN, 16: road half-width in pixels at the horizon row (r=0).
- BUMP_MIN, 4: kerb width in pixels at the horizon row.
- STRIPE_BIT, 4: bit of (scroll + depth) that selects kerb colour.
- CENTER_X, 320: road centre X with zero curvature.

Ports:
- pixel_clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse at vertical blank start.
- scroll_pos  in  16  distance travelled, unsigned.
- curve  in  8  curvature, signed two's complement.
- wr_en  out  1  RAM write strobe.
- wr_addr  out  9  RAM address, equal to row r.
- wr_data  out  32  line word. Bit 31 = kerb stripe colour (1 white, 0 red); bit 30 = 0; [29:20] = road_r; [19:10] = bump_l; [9:0] = road_l.
- busy  out  1  high while a frame is being generated.
- done  out  1  one-cycle pulse after the last row is written.

Behaviour:
- Reset (asynchronous) values: wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, state=IDLE. All accumulators are cleared.
- States are IDLE, INIT, CALC, WRITE, DONE.
- IDLE: frame_start=1 moves to INIT.
- INIT:
  - Latch scroll_pos and curve.
  - Set r=LINES-1 (bottom row), center_fx = CENTER_X<<6 (signed Q11.6, 17 bits), dx=0 (16-bit signed), depth=0 (16-bit).
  - Go to CALC.
- CALC:
  - c = center_fx>>>6; hr = HALF_MIN + r; b = BUMP_MIN + (r>>3).
  - bump_l = c-hr-b; road_l = c-hr; road_r = c+hr. Compute at 12-bit signed width.
  - Clamp each edge to 0..639; never wrap.
  - stripe = bit STRIPE_BIT of (scroll_lat + depth), mod 2^16.
  - Register wr_data. Go to WRITE.
- WRITE:
  - wr_en=1 for exactly this cycle, with wr_addr=r.
  - Update dx += sext(curve); center_fx += new dx (saturate at the 17-bit signed limits); depth += (LINES-1-r)>>2.
  - If r==0, go to DONE; else r-1 and go to CALC.
- DONE: done=1 for one cycle, then IDLE.
- busy is high in INIT, CALC, WRITE and DONE.
- Timing, with frame_start sampled at edge N:
  - First wr_en at cycle N+3.
  - Row k (k=0 is bottom) is written at N+3+2k.
  - Last write is at N+1+2*LINES; done at N+2+2*LINES.
  - 483 cycles in total at default LINES.
- frame_start while busy is ignored; the current pass continues unchanged.
- scroll_pos and curve changes after INIT have no effect until the next frame.
- reset mid-pass aborts immediately to IDLE with all outputs at reset values; RAM keeps partial contents.
- wr_en is never asserted outside WRITE.

Optional Feature:
- TRACK_OVERRUN_CNT_EN defined:
  - Adds output overrun_cnt [7:0].
  - It counts frame_start pulses that arrive while busy=1 and saturates at 255.
  - It is cleared only by reset.
- Undefined: the port and counter are absent; overruns are silently ignored.

Test Plan:
- Default geometry: scroll_pos=0, curve=0, pulse frame_start.
  - First write: addr=239, road_r=575, bump_l=32, road_l=65, bit31=0.
  - Last write: addr=0, road_r=336, bump_l=300, road_l=304.
  - Exactly 240 wr_en pulses.
- Timing: frame_start at edge N → wr_en at N+3, N+5, …; done pulse alone at N+482; busy falls at N+483.
- Stripe: scroll_pos=16, curve=0 → addr 239 word has bit31=1. With scroll_pos=0, bit31 toggles at the first row where depth reaches 16.
- Clamp: curve=+127 → road_r rises monotonically and saturates at 639; no edge ever exceeds 639 or wraps. curve=-128 → bump_l saturates at 0.
- Overrun: second frame_start 100 cycles into a pass → pass finishes unchanged, 240 writes, no restart. With TRACK_OVERRUN_CNT_EN, overrun_cnt=1.
- Reset: assert reset at the 50th write → wr_en, busy, done go 0 immediately. A following frame_start yields a full, correct 240-row pass.

Source files
------------

// File: rtl/track_line_gen.sv
// Per-frame road scanline geometry generator: writes one 32-bit line word per row into the track line RAM.
// Optional TRACK_OVERRUN_CNT_EN adds a saturating count of frame_start pulses that arrive while busy.
module track_line_gen #(
  parameter int LINES      = 240,
  parameter int HALF_MIN   = 16,
  parameter int BUMP_MIN   = 4,
  parameter int STRIPE_BIT = 4,
  parameter int CENTER_X   = 320
) (
  input  logic        pixel_clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic [15:0] scroll_pos,
  input  logic [7:0]  curve,
  output logic        wr_en,
  output logic [8:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done
`ifdef TRACK_OVERRUN_CNT_EN
  ,
  output logic [7:0]  overrun_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, INIT, CALC, WRITE, DONE} state_t;

  state_t             state_q, state_d;
  logic [8:0]         row_q, row_d;
  logic signed [16:0] centerFx_q, centerFx_d;
  logic signed [15:0] dx_q, dx_d;
  logic [15:0]        depth_q, depth_d;
  logic [15:0]        scroll_q, scroll_d;
  logic [7:0]         curve_q, curve_d;
  logic [31:0]        data_q, data_d;

  logic signed [11:0] cen, half, bumpW, roadL, bumpL, roadR;
  logic [15:0]        phase;
  logic signed [15:0] dxNew;
  logic signed [17:0] centerSum;
  logic [8:0]         rowsDone;

  // Edges are clamped to the visible 0..639 range rather than allowed to wrap.
  function automatic logic [9:0] clampEdge(input logic signed [11:0] x);
    if (x < 12'sd0)
      return 10'd0;
    else if (x > 12'sd639)
      return 10'd639;
    else
      return x[9:0];
  endfunction

  always_comb begin
    cen       = {centerFx_q[16], centerFx_q[16:6]};
    half      = 12'(HALF_MIN) + {3'b000, row_q};
    bumpW     = 12'(BUMP_MIN) + {6'b000000, row_q[8:3]};
    roadL     = cen - half;
    bumpL     = roadL - bumpW;
    roadR     = cen + half;
    phase     = scroll_q + depth_q;
    dxNew     = dx_q + {{8{curve_q[7]}}, curve_q};
    centerSum = {centerFx_q[16], centerFx_q} + {{2{dxNew[15]}}, dxNew};
    rowsDone  = 9'(LINES - 1) - row_q;
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      row_q      <= '0;
      centerFx_q <= '0;
      dx_q       <= '0;
      depth_q    <= '0;
      scroll_q   <= '0;
      curve_q    <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      centerFx_q <= centerFx_d;
      dx_q       <= dx_d;
      depth_q    <= depth_d;
      scroll_q   <= scroll_d;
      curve_q    <= curve_d;
      data_q     <= data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    centerFx_d = centerFx_q;
    dx_d       = dx_q;
    depth_d    = depth_q;
    scroll_d   = scroll_q;
    curve_d    = curve_q;
    data_d     = data_q;
    case (state_q)
      IDLE: begin
        if (frame_start) state_d = INIT;
      end
      INIT: begin
        scroll_d   = scroll_pos;
        curve_d    = curve;
        row_d      = 9'(LINES - 1);
        centerFx_d = 17'(CENTER_X * 64);
        dx_d       = '0;
        depth_d    = '0;
        state_d    = CALC;
      end
      CALC: begin
        data_d  = {phase[STRIPE_BIT], 1'b0, clampEdge(roadR), clampEdge(bumpL), clampEdge(roadL)};
        state_d = WRITE;
      end
      WRITE: begin
        // Curvature accumulates twice: curve into dx, then the new dx into the centre.
        dx_d = dxNew;
        if (centerSum > 18'sd65535)
          centerFx_d = 17'sd65535;
        else if (centerSum < -18'sd65536)
          centerFx_d = -17'sd65536;
        else
          centerFx_d = centerSum[16:0];
        depth_d = depth_q + {9'd0, rowsDone[8:2]};
        if (row_q == 9'd0) begin
          state_d = DONE;
        end else begin
          row_d   = row_q - 9'd1;
          state_d = CALC;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_en   = (state_q == WRITE);
  assign wr_addr = row_q;
  assign wr_data = data_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);

`ifdef TRACK_OVERRUN_CNT_EN
  logic [7:0] overrunCnt_q;

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset)
      overrunCnt_q <= '0;
    else if (frame_start && busy && (overrunCnt_q != 8'hFF))
      overrunCnt_q <= overrunCnt_q + 8'd1;
  end

  assign overrun_cnt = overrunCnt_q;
`else
  // Without the counter, frame_start while busy is simply dropped.
`endif

endmodule
